// File: rtl/tqvp_hx2003_pulse_pkg.sv
// Shared types and constants for the pulse-transmitter program sequencer.
// Contents: FSM state enum, irq_mode bit positions, symbol encodings and the
// phase-dispatch helper used when a new symbol becomes current.
package tqvp_hx2003_pulse_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StHigh,
    StLow,
    StNext,
    StDone
  } seq_state_e;

  localparam int unsigned IRQ_WRAP_BIT = 0;
  localparam int unsigned IRQ_DONE_BIT = 1;

  localparam logic SYM_A = 1'b0;
  localparam logic SYM_B = 1'b1;

  // First phase of a symbol: a zero duration skips that phase entirely.
  function automatic seq_state_e dispatch(input logic [7:0] dur_high, input logic [7:0] dur_low);
    if (dur_high != 8'd0) return StHigh;
    if (dur_low != 8'd0) return StLow;
    return StNext;
  endfunction

endpackage

// File: rtl/tqvp_hx2003_phase_counter.sv
// 8-bit phase duration counter.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   load_i      load load_val_i (has priority over tick_i)
//   load_val_i  phase length in ticks
//   tick_i      decrement strobe (already qualified by the caller)
//   expire_o    combinational: this tick is the last one of the phase
module tqvp_hx2003_phase_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       tick_i,
  output logic       expire_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = tick_i && (cnt_q == 8'd1);

endmodule

// File: rtl/tqvp_hx2003_pulse_sequencer.sv
// Program sequencer for the pulse transmitter. Walks a 1-bit-per-symbol program
// held in 32-bit data memory words and plays HIGH/LOW phases timed in prescaler ticks.
// Optional feature macro: PULSE_SEQ_CARRIER_EN (adds carrier_in, gates HIGH with it).
// Ports:
//   clk, rst (sync, active-high)
//   start, loop, irq_mode[1:0]       control (sampled live)
//   prog_start, prog_end [PC_W]       program symbol range (may wrap through 0)
//   dur_{high,low}_{a,b} [8]          phase lengths per symbol value
//   tick                              prescaler strobe
//   mem_rd_en, mem_rd_addr, mem_rd_data  word read port (data valid one cycle later)
//   carrier_in                        carrier (only with PULSE_SEQ_CARRIER_EN)
//   pulse_out, busy, pc_out, irq      status / output
module tqvp_hx2003_pulse_sequencer
  import tqvp_hx2003_pulse_pkg::*;
#(
  parameter int unsigned PC_W = 7,
  localparam int unsigned MA_W = PC_W - 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            loop,
  input  logic [1:0]      irq_mode,
  input  logic [PC_W-1:0] prog_start,
  input  logic [PC_W-1:0] prog_end,
  input  logic [7:0]      dur_high_a,
  input  logic [7:0]      dur_high_b,
  input  logic [7:0]      dur_low_a,
  input  logic [7:0]      dur_low_b,
  input  logic            tick,
  output logic            mem_rd_en,
  output logic [MA_W-1:0] mem_rd_addr,
  input  logic [31:0]     mem_rd_data,
`ifdef PULSE_SEQ_CARRIER_EN
  input  logic            carrier_in,
`endif
  output logic            pulse_out,
  output logic            busy,
  output logic [PC_W-1:0] pc_out,
  output logic            irq
);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [31:0]     word_q, word_d;
  logic            pulse_q, irq_q, irq_d;
  logic            sym;
  logic            cnt_load, cnt_tick, cnt_expire;
  logic [7:0]      cnt_load_val;

  function automatic logic [7:0] pick(input logic s, input logic [7:0] a, input logic [7:0] b);
    return (s == SYM_B) ? b : a;
  endfunction

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    word_d       = word_q;
    irq_d        = 1'b0;
    pc_inc       = pc_q + PC_W'(1);
    sym          = word_q[pc_q[4:0]];
    cnt_load     = 1'b0;
    cnt_load_val = 8'd0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pc_d    = prog_start;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StWait;
      StWait: begin
        word_d  = mem_rd_data;
        sym     = mem_rd_data[pc_q[4:0]];
        state_d = dispatch(pick(sym, dur_high_a, dur_high_b), pick(sym, dur_low_a, dur_low_b));
      end
      StHigh: begin
        if (cnt_expire) begin
          state_d = (pick(sym, dur_low_a, dur_low_b) != 8'd0) ? StLow : StNext;
        end
      end
      StLow: begin
        if (cnt_expire) state_d = StNext;
      end
      StNext: begin
        if (pc_q == prog_end) begin
          if (loop) begin
            pc_d    = prog_start;
            irq_d   = irq_mode[IRQ_WRAP_BIT];
            state_d = StFetch;
          end else begin
            irq_d   = irq_mode[IRQ_DONE_BIT];
            state_d = StDone;
          end
        end else begin
          pc_d = pc_inc;
          if (pc_inc[PC_W-1:5] != pc_q[PC_W-1:5]) begin
            state_d = StFetch;
          end else begin
            // Next symbol lives in the cached word; no memory round trip.
            sym     = word_q[pc_inc[4:0]];
            state_d = dispatch(pick(sym, dur_high_a, dur_high_b),
                               pick(sym, dur_low_a, dur_low_b));
          end
        end
      end
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase

    // Dropping start overrides everything, including a pending wrap irq.
    if (!start) begin
      state_d = StIdle;
      pc_d    = pc_q;
      irq_d   = 1'b0;
    end

    // Counter is (re)loaded only when a phase is entered.
    if ((state_d == StHigh) && (state_q != StHigh)) begin
      cnt_load     = 1'b1;
      cnt_load_val = pick(sym, dur_high_a, dur_high_b);
    end else if ((state_d == StLow) && (state_q != StLow)) begin
      cnt_load     = 1'b1;
      cnt_load_val = pick(sym, dur_low_a, dur_low_b);
    end
  end

  assign cnt_tick = tick && ((state_q == StHigh) || (state_q == StLow));

  tqvp_hx2003_phase_counter u_phase_counter (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .tick_i     (cnt_tick),
    .expire_o   (cnt_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      word_q  <= 32'd0;
      pulse_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      word_q  <= word_d;
      pulse_q <= (state_d == StHigh);
      irq_q   <= irq_d;
    end
  end

  assign mem_rd_en   = (state_q == StFetch);
  assign mem_rd_addr = pc_q[PC_W-1:5];
  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign pc_out      = pc_q;
  assign irq         = irq_q;

`ifdef PULSE_SEQ_CARRIER_EN
  assign pulse_out = pulse_q & carrier_in;
`else
  assign pulse_out = pulse_q;
`endif

endmodule

// File: tb/tb_tqvp_hx2003_pulse_sequencer.sv
// Scoreboard bench for tqvp_hx2003_pulse_sequencer: stimulus pushes the expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_tqvp_hx2003_pulse_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, loop, tick;
  logic [1:0]  irq_mode;
  logic [6:0]  prog_start, prog_end;
  logic [7:0]  dur_high_a, dur_high_b, dur_low_a, dur_low_b;
  logic        mem_rd_en;
  logic [1:0]  mem_rd_addr;
  logic [31:0] mem_rd_data = 32'd0;
  logic        pulse_out, busy, irq;
  logic [6:0]  pc_out;
`ifdef PULSE_SEQ_CARRIER_EN
  logic        carrier_in = 1'b1;
`endif

  logic [31:0] mem [4];

  always #5 clk = ~clk;

  tqvp_hx2003_pulse_sequencer #(.PC_W(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .loop        (loop),
    .irq_mode    (irq_mode),
    .prog_start  (prog_start),
    .prog_end    (prog_end),
    .dur_high_a  (dur_high_a),
    .dur_high_b  (dur_high_b),
    .dur_low_a   (dur_low_a),
    .dur_low_b   (dur_low_b),
    .tick        (tick),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
`ifdef PULSE_SEQ_CARRIER_EN
    .carrier_in  (carrier_in),
`endif
    .pulse_out   (pulse_out),
    .busy        (busy),
    .pc_out      (pc_out),
    .irq         (irq)
  );

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  typedef struct {
    string      tag;
    logic       pulse;
    logic       busy;
    logic       irq;
    logic       rd;
    int         pc;    // negative: do not check
    logic [1:0] addr;  // checked only when rd is expected
  } exp_t;

  exp_t  exp_q[$];
  string cur;
  int    n_vec  = 0;
  int    n_fail = 0;

  task automatic e(input logic p, input logic b, input logic i, input logic r,
                   input int pc, input logic [1:0] a);
    exp_t x;
    x.tag = cur; x.pulse = p; x.busy = b; x.irq = i; x.rd = r; x.pc = pc; x.addr = a;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t x;
      logic ok;
      x = exp_q.pop_front();
      n_vec++;
      ok = (pulse_out === x.pulse) && (busy === x.busy) && (irq === x.irq) &&
           (mem_rd_en === x.rd);
      if (x.pc >= 0) ok = ok && (pc_out === 7'(x.pc));
      if (x.rd) ok = ok && (mem_rd_addr === x.addr);
      if (!ok) begin
        n_fail++;
        $display("FAIL %s vec%0d: got pulse=%b busy=%b irq=%b rd=%b addr=%0d pc=%0d; want pulse=%b busy=%b irq=%b rd=%b addr=%0d pc=%0d",
                 x.tag, n_vec, pulse_out, busy, irq, mem_rd_en, mem_rd_addr, pc_out,
                 x.pulse, x.busy, x.irq, x.rd, x.addr, x.pc);
      end
    end
  end

  task automatic drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 300) begin
      @(posedge clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d pending, want 0", cur, exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  task automatic lead_in();
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic durs(input logic [7:0] ha, input logic [7:0] la,
                      input logic [7:0] hb, input logic [7:0] lb);
    dur_high_a = ha; dur_low_a = la; dur_high_b = hb; dur_low_b = lb;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; loop = 1'b0; tick = 1'b1; irq_mode = 2'b00;
    prog_start = 7'd0; prog_end = 7'd0;
    durs(8'd0, 8'd0, 8'd0, 8'd0);
    mem[0] = 32'b10; mem[1] = 32'd0; mem[2] = 32'd0; mem[3] = 32'd0;

    // Reset state
    cur = "reset";
    @(posedge clk); #1;
    repeat (2) e(0, 0, 0, 0, 0, 0);
    drain();
    rst = 1'b0;

    // 1: two symbols, A then B, done irq
    lead_in();
    cur = "basic";
    durs(8'd2, 8'd3, 8'd1, 8'd1);
    prog_start = 7'd0; prog_end = 7'd1; loop = 1'b0; irq_mode = 2'b10; start = 1'b1;
    e(0, 0, 0, 0, -1, 0);
    e(0, 1, 0, 1, 0, 0);
    e(0, 1, 0, 0, 0, 0);
    repeat (2) e(1, 1, 0, 0, 0, 0);
    repeat (4) e(0, 1, 0, 0, 0, 0);
    e(1, 1, 0, 0, 1, 0);
    repeat (2) e(0, 1, 0, 0, 1, 0);
    e(0, 0, 1, 0, 1, 0);
    e(0, 0, 0, 0, 1, 0);
    drain();

    // 2: loop with wrap irq; start falls on the cycle a second wrap would fire
    lead_in();
    cur = "loop";
    durs(8'd1, 8'd1, 8'd1, 8'd1);
    prog_start = 7'd3; prog_end = 7'd4; loop = 1'b1; irq_mode = 2'b01; start = 1'b1;
    e(0, 0, 0, 0, -1, 0);
    for (int k = 0; k < 2; k++) begin
      e(0, 1, (k == 1), 1, 3, 0);
      e(0, 1, 0, 0, 3, 0);
      e(1, 1, 0, 0, 3, 0);
      repeat (2) e(0, 1, 0, 0, 3, 0);
      e(1, 1, 0, 0, 4, 0);
      repeat (2) e(0, 1, 0, 0, 4, 0);
    end
    repeat (2) e(0, 0, 0, 0, -1, 0);
    repeat (16) @(posedge clk);
    #1 start = 1'b0;
    drain();

    // 3a: zero HIGH duration skips straight to LOW
    lead_in();
    cur = "skip_high";
    durs(8'd0, 8'd4, 8'd1, 8'd1);
    prog_start = 7'd0; prog_end = 7'd0; loop = 1'b0; irq_mode = 2'b00; start = 1'b1;
    e(0, 0, 0, 0, -1, 0);
    e(0, 1, 0, 1, 0, 0);
    repeat (6) e(0, 1, 0, 0, 0, 0);
    repeat (2) e(0, 0, 0, 0, 0, 0);
    drain();

    // 3b: all durations zero -> NEXT every cycle
    lead_in();
    cur = "all_zero";
    durs(8'd0, 8'd0, 8'd0, 8'd0);
    prog_start = 7'd0; prog_end = 7'd2; irq_mode = 2'b10; start = 1'b1;
    e(0, 0, 0, 0, -1, 0);
    e(0, 1, 0, 1, 0, 0);
    repeat (2) e(0, 1, 0, 0, 0, 0);
    e(0, 1, 0, 0, 1, 0);
    e(0, 1, 0, 0, 2, 0);
    e(0, 0, 1, 0, 2, 0);
    e(0, 0, 0, 0, 2, 0);
    drain();

    // 4: abort mid-HIGH, then restart from a new prog_start
    lead_in();
    cur = "abort";
    durs(8'd5, 8'd1, 8'd1, 8'd1);
    prog_start = 7'd0; prog_end = 7'd0; loop = 1'b1; irq_mode = 2'b11; start = 1'b1;
    e(0, 0, 0, 0, -1, 0);
    e(0, 1, 0, 1, 0, 0);
    e(0, 1, 0, 0, 0, 0);
    repeat (2) e(1, 1, 0, 0, 0, 0);
    repeat (2) e(0, 0, 0, 0, 0, 0);
    e(0, 1, 0, 1, 5, 0);
    e(0, 1, 0, 0, 5, 0);
    e(1, 1, 0, 0, 5, 0);
    repeat (4) @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 prog_start = 7'd5; prog_end = 7'd5; start = 1'b1;
    drain();

    // 5a: crossing a word boundary refetches exactly once
    lead_in();
    cur = "word_cross";
    durs(8'd0, 8'd0, 8'd0, 8'd0);
    prog_start = 7'd30; prog_end = 7'd33; loop = 1'b0; irq_mode = 2'b00; start = 1'b1;
    e(0, 0, 0, 0, -1, 0);
    e(0, 1, 0, 1, 30, 0);
    repeat (2) e(0, 1, 0, 0, 30, 0);
    e(0, 1, 0, 0, 31, 0);
    e(0, 1, 0, 1, 32, 1);
    repeat (2) e(0, 1, 0, 0, 32, 0);
    e(0, 1, 0, 0, 33, 0);
    repeat (2) e(0, 0, 0, 0, 33, 0);
    drain();

    // 5b: program wraps from symbol 127 to symbol 0
    lead_in();
    cur = "pc_wrap";
    prog_start = 7'd127; prog_end = 7'd0; start = 1'b1;
    e(0, 0, 0, 0, -1, 0);
    e(0, 1, 0, 1, 127, 3);
    repeat (2) e(0, 1, 0, 0, 127, 0);
    e(0, 1, 0, 1, 0, 0);
    repeat (2) e(0, 1, 0, 0, 0, 0);
    repeat (2) e(0, 0, 0, 0, 0, 0);
    drain();

    start = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
